// File: rtl/mor1kx_wb_stage_cappuccino_pkg.sv
// Shared encodings for the cappuccino writeback stage and the load aligner.
package mor1kx_wb_stage_cappuccino_pkg;

    localparam int unsigned LDAT_WIDTH = 32;
    localparam int unsigned LSU_LEN_W  = 2;
    localparam int unsigned LSU_ADR_W  = 2;

    localparam logic [LSU_LEN_W-1:0] LSU_LEN_BYTE = 2'b00;
    localparam logic [LSU_LEN_W-1:0] LSU_LEN_HALF = 2'b01;
    localparam logic [LSU_LEN_W-1:0] LSU_LEN_WORD = 2'b10;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } wb_state_e;

    // Shape of a pending load, held while waiting on the LSU
    typedef struct packed {
        logic [LSU_LEN_W-1:0] length;
        logic                 zext;
        logic [LSU_ADR_W-1:0] adr;
    } ld_ctrl_t;

endpackage

// File: rtl/mor1kx_load_align.sv
// Big-endian lane select and sign/zero extension of a raw 32-bit load word.
module mor1kx_load_align
    import mor1kx_wb_stage_cappuccino_pkg::*;
(
    input  logic [LDAT_WIDTH-1:0] ldat_i,
    input  logic [LSU_ADR_W-1:0]  adr_i,
    input  logic [LSU_LEN_W-1:0]  length_i,
    input  logic                  zext_i,
    output logic [LDAT_WIDTH-1:0] dat_c_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = ldat_i[31:24];
        case (adr_i)
            2'b00:   byte_lane = ldat_i[31:24];
            2'b01:   byte_lane = ldat_i[23:16];
            2'b10:   byte_lane = ldat_i[15:8];
            default: byte_lane = ldat_i[7:0];
        endcase
        half_lane = adr_i[1] ? ldat_i[15:0] : ldat_i[31:16];
    end

    // Length 11 falls through to word
    always_comb begin
        dat_c_o = ldat_i;
        case (length_i)
            LSU_LEN_BYTE: dat_c_o = zext_i ? {24'h0, byte_lane}
                                           : {{24{byte_lane[7]}}, byte_lane};
            LSU_LEN_HALF: dat_c_o = zext_i ? {16'h0, half_lane}
                                           : {{16{half_lane[15]}}, half_lane};
            LSU_LEN_WORD: dat_c_o = ldat_i;
            default:      dat_c_o = ldat_i;
        endcase
    end

endmodule

// File: rtl/mor1kx_wb_stage_cappuccino.sv
// Cappuccino writeback stage: result select, load hold-off and GPR write strobe.
module mor1kx_wb_stage_cappuccino
    import mor1kx_wb_stage_cappuccino_pkg::*;
#(
    parameter int unsigned OPTION_OPERAND_WIDTH = 32,
    parameter int unsigned OPTION_RF_ADDR_WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            padv_wb_i,
    input  logic                            pipeline_flush_i,
    input  logic                            ctrl_rf_wb_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] ctrl_rfd_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_alu_result_i,
    input  logic                            ctrl_op_mul_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_mul_result_i,
    input  logic                            ctrl_op_mfspr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_mfspr_dat_i,
    input  logic                            ctrl_op_lsu_load_i,
    input  logic [1:0]                      ctrl_lsu_length_i,
    input  logic                            ctrl_lsu_zext_i,
    input  logic [1:0]                      ctrl_lsu_adr_i,
    input  logic                            lsu_valid_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] lsu_ldat_i,
    output logic                            wb_rf_wb_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] result_o,
    output logic                            wb_busy_o
);

    wb_state_e                       state_q, state_d;
    logic                            wb_q, wb_d;
    logic [OPTION_RF_ADDR_WIDTH-1:0] rfd_q, rfd_d;
    logic [OPTION_OPERAND_WIDTH-1:0] result_q, result_d;
    ld_ctrl_t                        ld_q, ld_d;
    logic                            ld_we_q, ld_we_d;
    logic [OPTION_RF_ADDR_WIDTH-1:0] ld_rd_q, ld_rd_d;

    ld_ctrl_t                        align_sel;
    logic [OPTION_OPERAND_WIDTH-1:0] aligned;
    logic                            ctrl_we;

    assign ctrl_we = ctrl_rf_wb_i && (ctrl_rfd_adr_i != '0);

    // A waiting load aligns with its latched shape; otherwise use ctrl's
    always_comb begin
        align_sel = ld_q;
        if (state_q == IDLE) begin
            align_sel = '{length: ctrl_lsu_length_i,
                          zext:   ctrl_lsu_zext_i,
                          adr:    ctrl_lsu_adr_i};
        end
    end

    mor1kx_load_align u_load_align (
        .ldat_i   (lsu_ldat_i),
        .adr_i    (align_sel.adr),
        .length_i (align_sel.length),
        .zext_i   (align_sel.zext),
        .dat_c_o  (aligned)
    );

    always_comb begin
        state_d  = state_q;
        wb_d     = 1'b0;
        rfd_d    = rfd_q;
        result_d = result_q;
        ld_d     = ld_q;
        ld_we_d  = ld_we_q;
        ld_rd_d  = ld_rd_q;
        if (pipeline_flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (padv_wb_i) begin
                        if (ctrl_op_lsu_load_i && !lsu_valid_i) begin
                            state_d = LOAD_WAIT;
                            ld_d    = align_sel;
                            ld_we_d = ctrl_we;
                            ld_rd_d = ctrl_rfd_adr_i;
                        end else begin
                            wb_d  = ctrl_we;
                            rfd_d = ctrl_rfd_adr_i;
                            if (ctrl_op_lsu_load_i)
                                result_d = aligned;
                            else if (ctrl_op_mfspr_i)
                                result_d = ctrl_mfspr_dat_i;
                            else if (ctrl_op_mul_i)
                                result_d = ctrl_mul_result_i;
                            else
                                result_d = ctrl_alu_result_i;
                        end
                    end
                end
                LOAD_WAIT: begin
                    if (lsu_valid_i) begin
                        state_d  = IDLE;
                        wb_d     = ld_we_q;
                        rfd_d    = ld_rd_q;
                        result_d = aligned;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wb_q     <= 1'b0;
            rfd_q    <= '0;
            result_q <= '0;
            ld_q     <= '0;
            ld_we_q  <= 1'b0;
            ld_rd_q  <= '0;
        end else begin
            state_q  <= state_d;
            wb_q     <= wb_d;
            rfd_q    <= rfd_d;
            result_q <= result_d;
            ld_q     <= ld_d;
            ld_we_q  <= ld_we_d;
            ld_rd_q  <= ld_rd_d;
        end
    end

    assign wb_rf_wb_o   = wb_q;
    assign wb_rfd_adr_o = rfd_q;
    assign result_o     = result_q;
    assign wb_busy_o    = (state_q == LOAD_WAIT);

endmodule

// File: tb/tb_mor1kx_wb_stage_cappuccino.sv
// Directed-vector bench for the cappuccino writeback stage.
module tb_mor1kx_wb_stage_cappuccino;

    logic        clk;
    logic        rst_n;
    logic        padv_wb;
    logic        flush;
    logic        rf_wb;
    logic [4:0]  rfd_adr;
    logic [31:0] alu_result;
    logic        op_mul;
    logic [31:0] mul_result;
    logic        op_mfspr;
    logic [31:0] mfspr_dat;
    logic        op_load;
    logic [1:0]  lsu_length;
    logic        lsu_zext;
    logic [1:0]  lsu_adr;
    logic        lsu_valid;
    logic [31:0] lsu_ldat;
    logic        wb_rf_wb;
    logic [4:0]  wb_rfd_adr;
    logic [31:0] result;
    logic        wb_busy;

    int vectors;
    int miscompares;

    mor1kx_wb_stage_cappuccino dut (
        .clk               (clk),
        .rst               (rst_n),
        .padv_wb_i         (padv_wb),
        .pipeline_flush_i  (flush),
        .ctrl_rf_wb_i      (rf_wb),
        .ctrl_rfd_adr_i    (rfd_adr),
        .ctrl_alu_result_i (alu_result),
        .ctrl_op_mul_i     (op_mul),
        .ctrl_mul_result_i (mul_result),
        .ctrl_op_mfspr_i   (op_mfspr),
        .ctrl_mfspr_dat_i  (mfspr_dat),
        .ctrl_op_lsu_load_i(op_load),
        .ctrl_lsu_length_i (lsu_length),
        .ctrl_lsu_zext_i   (lsu_zext),
        .ctrl_lsu_adr_i    (lsu_adr),
        .lsu_valid_i       (lsu_valid),
        .lsu_ldat_i        (lsu_ldat),
        .wb_rf_wb_o        (wb_rf_wb),
        .wb_rfd_adr_o      (wb_rfd_adr),
        .result_o          (result),
        .wb_busy_o         (wb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream must hold off while a load is pending
    always @(posedge clk) begin
        if (rst_n && wb_busy)
            assert (!padv_wb) else $error("padv_wb_i asserted while wb_busy_o");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic wb, input logic [4:0] adr,
                             input logic [31:0] res, input logic busy);
        check({tag, ".wb"},   32'(wb_rf_wb),   32'(wb));
        check({tag, ".adr"},  32'(wb_rfd_adr), 32'(adr));
        check({tag, ".res"},  result,          res);
        check({tag, ".busy"}, 32'(wb_busy),    32'(busy));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        padv_wb    = 1'b0;
        flush      = 1'b0;
        rf_wb      = 1'b0;
        rfd_adr    = 5'd0;
        alu_result = 32'h0;
        op_mul     = 1'b0;
        mul_result = 32'h0;
        op_mfspr   = 1'b0;
        mfspr_dat  = 32'h0;
        op_load    = 1'b0;
        lsu_length = 2'b00;
        lsu_zext   = 1'b0;
        lsu_adr    = 2'b00;
        lsu_valid  = 1'b0;
        lsu_ldat   = 32'h0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [31:0] alu);
        idle_inputs();
        padv_wb    = 1'b1;
        rf_wb      = 1'b1;
        rfd_adr    = rd;
        alu_result = alu;
    endtask

    task automatic issue_load(input logic [4:0] rd, input logic [1:0] len, input logic zext,
                              input logic [1:0] adr, input logic valid, input logic [31:0] ldat);
        issue(rd, 32'h0BAD_0BAD);
        op_load    = 1'b1;
        lsu_length = len;
        lsu_zext   = zext;
        lsu_adr    = adr;
        lsu_valid  = valid;
        lsu_ldat   = ldat;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        check_out("reset", 1'b0, 5'd0, 32'h0, 1'b0);
        rst_n = 1'b1;
        tick();

        // ALU write, then the strobe drops
        issue(5'd3, 32'h1234_5678);
        tick();
        idle_inputs();
        check_out("alu", 1'b1, 5'd3, 32'h1234_5678, 1'b0);
        tick();
        check_out("alu_drop", 1'b0, 5'd3, 32'h1234_5678, 1'b0);

        // r0 write suppressed
        issue(5'd0, 32'h0000_0055);
        tick();
        idle_inputs();
        check_out("r0", 1'b0, 5'd0, 32'h0000_0055, 1'b0);

        // lbs adr=2, data three cycles late
        issue_load(5'd4, 2'b00, 1'b0, 2'b10, 1'b0, 32'hFFFF_FFFF);
        tick();
        idle_inputs();
        check_out("lbs_wait1", 1'b0, 5'd0, 32'h0000_0055, 1'b1);
        tick();
        check_out("lbs_wait2", 1'b0, 5'd0, 32'h0000_0055, 1'b1);
        tick();
        check_out("lbs_wait3", 1'b0, 5'd0, 32'h0000_0055, 1'b1);
        lsu_valid = 1'b1;
        lsu_ldat  = 32'h0011_8033;
        tick();
        idle_inputs();
        check_out("lbs_done", 1'b1, 5'd4, 32'hFFFF_FF80, 1'b0);
        tick();
        check_out("lbs_drop", 1'b0, 5'd4, 32'hFFFF_FF80, 1'b0);

        // Same-cycle loads, back to back
        issue_load(5'd5, 2'b01, 1'b1, 2'b10, 1'b1, 32'hAAAA_8001);
        tick();
        check_out("lhz", 1'b1, 5'd5, 32'h0000_8001, 1'b0);
        issue_load(5'd6, 2'b01, 1'b0, 2'b00, 1'b1, 32'h8001_0000);
        tick();
        check_out("lhs", 1'b1, 5'd6, 32'hFFFF_8001, 1'b0);
        issue_load(5'd12, 2'b11, 1'b0, 2'b11, 1'b1, 32'hCAFE_F00D);
        tick();
        check_out("len11", 1'b1, 5'd12, 32'hCAFE_F00D, 1'b0);
        issue_load(5'd13, 2'b00, 1'b1, 2'b11, 1'b1, 32'h1234_56F0);
        tick();
        check_out("lbz3", 1'b1, 5'd13, 32'h0000_00F0, 1'b0);
        issue_load(5'd14, 2'b01, 1'b0, 2'b11, 1'b1, 32'h7FFF_8123);
        tick();
        idle_inputs();
        check_out("lhs3", 1'b1, 5'd14, 32'hFFFF_8123, 1'b0);

        // Flush while waiting; late data is dropped
        issue_load(5'd8, 2'b10, 1'b0, 2'b00, 1'b0, 32'h0);
        tick();
        idle_inputs();
        check_out("flush_wait", 1'b0, 5'd14, 32'hFFFF_8123, 1'b1);
        flush = 1'b1;
        tick();
        idle_inputs();
        check_out("flush", 1'b0, 5'd14, 32'hFFFF_8123, 1'b0);
        lsu_valid = 1'b1;
        lsu_ldat  = 32'h5555_5555;
        tick();
        idle_inputs();
        check_out("flush_late", 1'b0, 5'd14, 32'hFFFF_8123, 1'b0);
        issue(5'd7, 32'h0000_0001);
        op_mfspr  = 1'b1;
        mfspr_dat = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        check_out("mfspr", 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0);

        // Flush beats padv and lsu_valid in the same cycle
        issue_load(5'd9, 2'b10, 1'b0, 2'b00, 1'b1, 32'h9999_9999);
        flush = 1'b1;
        tick();
        idle_inputs();
        check_out("flush_padv", 1'b0, 5'd7, 32'hDEAD_BEEF, 1'b0);

        // Priority: mfspr over mul over alu
        issue(5'd10, 32'h3333_3333);
        op_mul     = 1'b1;
        mul_result = 32'h1111_1111;
        op_mfspr   = 1'b1;
        mfspr_dat  = 32'h2222_2222;
        tick();
        check_out("prio_mfspr", 1'b1, 5'd10, 32'h2222_2222, 1'b0);
        op_mfspr = 1'b0;
        rfd_adr  = 5'd11;
        tick();
        idle_inputs();
        check_out("prio_mul", 1'b1, 5'd11, 32'h1111_1111, 1'b0);

        // Asynchronous reset in the middle of a wait
        issue_load(5'd15, 2'b10, 1'b0, 2'b00, 1'b0, 32'h0);
        tick();
        idle_inputs();
        check_out("rst_wait", 1'b0, 5'd11, 32'h1111_1111, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("rst_async", 1'b0, 5'd0, 32'h0, 1'b0);
        tick();
        rst_n = 1'b1;
        lsu_valid = 1'b1;
        lsu_ldat  = 32'h7777_7777;
        tick();
        idle_inputs();
        check_out("rst_after", 1'b0, 5'd0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
